clb_cfg_sequencer: RTL
======================

// Module: clb_cfg_sequencer
// PURPOSE
//   Feeds CLB configuration ports. Accepts the host bitstream as a wide AXI stream and slices it
//   MSB-first into the narrow CLB stream. Pulses cfg to each CLB in index order and waits for that
//   CLB's cfg_ready. After the last CLB, drains padding to tlast and holds run high for the array.
// PARAMETERS
//   NUM_CLBS             4  number of CLBs driven (>=1)
//   IN_DATA_WIDTH        8  host stream word width
//   BITSTREAM_DATA_WIDTH 1  CLB stream width; must divide IN_DATA_WIDTH (elaboration error otherwise)
// PORTS
//   clk            in   1                    clock
//   rst_n          in   1                    reset, asynchronous, active-low
//   start          in   1                    begin (re)configuration; sampled in IDLE/DONE/ERROR only
//   host_bitstream slave axi_stream_if       IN_DATA_WIDTH host words; tlast = end of full image
//   cfg_bitstream  master axi_stream_if      BITSTREAM_DATA_WIDTH slices, broadcast to all CLBs
//   cfg            out  NUM_CLBS             one-hot, one-cycle configure pulse per CLB
//   cfg_ready      in   NUM_CLBS             per-CLB configuration-complete
//   run            out  1                    high while array configured (DONE)
//   busy           out  1                    high in KICK/STREAM/DRAIN
//   error          out  1                    sticky until next accepted start
// BEHAVIOUR
//   Reset (async): state IDLE; cfg=0, run=0, busy=0, error=0, cfg_bitstream.tvalid=0; shifter empty; clb_idx=0.
//   RATIO = IN_DATA_WIDTH/BITSTREAM_DATA_WIDTH. Shifter holds one word and a slice count 0..RATIO.
//   Slicing: out tdata = top BITSTREAM_DATA_WIDTH bits. Shift left on each out handshake. Count decrements.
//   host tready = busy && (count==0 || (count==1 && out handshake this cycle)); no bubble between words.
//   out tvalid = (state==STREAM) && count!=0. out tlast = 1 on the final slice of a host word with tlast.
//   out tready = cfg_bitstream.tready from CLB[clb_idx]. Ready from other CLBs is ignored.
//   Leftover slices are not flushed at CLB boundaries. They go to the next CLB; CLB images need not be word-aligned.
//   FSM:
//     IDLE   : start -> KICK; clb_idx=0, error=0.
//     KICK   : cfg[clb_idx]=1 for exactly 1 cycle; clear beats_seen -> STREAM.
//     STREAM : transfer slices. beats_seen set on the first out handshake.
//              cfg_ready[clb_idx] && beats_seen: last CLB -> DRAIN, else clb_idx++ -> KICK.
//              cfg_ready high before any beat (reconfig of a previously loaded CLB) is ignored.
//              Host tlast word fully consumed before the last CLB is ready -> ERROR.
//     DRAIN  : accept and discard host words (out tvalid=0). Handshake with tlast -> DONE.
//              If tlast was already consumed in STREAM -> DONE next cycle.
//     DONE   : run=1. start -> KICK with clb_idx=0; run drops the same cycle KICK is entered.
//     ERROR  : run=0, error=1, host tready=0; start -> KICK (clears error, empties shifter).
//   start in KICK/STREAM/DRAIN is ignored. A simultaneous cfg_ready and tlast in STREAM for the last CLB -> DRAIN then DONE.
//   clb_idx width $clog2(NUM_CLBS) (min 1). Compare to NUM_CLBS-1 at full width; no wrap.
//   Reset asserted mid-stream aborts immediately. No partial-state recovery; host restarts with a full image.
// STRUCTURE
//   Shared package fpga_cfg_pkg: t_cfg_seq_state enum (IDLE, KICK, STREAM, DRAIN, DONE, ERROR).
//   fpga_cfg_pkg also holds the RATIO helper function.
//   Sub-module cfg_width_converter: shifter, count, host tready/out tvalid logic. Ports: flush, enable.
//   Top holds the FSM, clb_idx, tready mux, cfg one-hot decode, status outputs.
// TESTING (NUM_CLBS=2, IN_DATA_WIDTH=8, BITSTREAM_DATA_WIDTH=1 unless noted)
//   1 Host sends 0xA5,0x3C (tlast on 0x3C). CLB models raise cfg_ready after 11 and 5 slices.
//     -> cfg[0] pulse, then slices 1,0,1,0,0,1,0,1,0,0,1 to CLB0; cfg[1] pulse; next 5 slices to CLB1.
//     -> 0-bit drain, then run=1 and error=0.
//   2 Same image with tlast on word 1 -> error=1, run=0 after the 8th slice; host tready=0 afterwards.
//   3 Host tvalid toggles every cycle and CLB tready low 2 of 3 cycles.
//     -> slice order identical to case 1; no slice duplicated or dropped (scoreboard).
//   4 In DONE, start=1 with CLB cfg_ready still high.
//     -> run=0 the same cycle, cfg=2'b01 next cycle, no advance until CLB0 takes >=1 slice.
//   5 rst_n low mid-STREAM after 3 slices -> all outputs 0 immediately (async); restart delivers the image from slice 0.
//   6 BITSTREAM_DATA_WIDTH=2, word 0xE4 -> slices 2'b11,2'b10,2'b01,2'b00. NUM_CLBS=1 completes to DONE.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared types and helpers for the CLB configuration path.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KICK,
        STREAM,
        DRAIN,
        DONE,
        ERROR
    } t_cfg_seq_state;

    // Number of narrow slices carried by one host word.
    function automatic int cfg_ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

endpackage

// File: rtl/cfg_width_converter.sv
// Wide-to-narrow stream slicer: holds one host word and emits it MSB-first, OUT_W bits per beat.
module cfg_width_converter
    import fpga_cfg_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             enable,
    input  logic             stream_enable,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             empty
);

    localparam int RATIO = cfg_ratio(IN_W, OUT_W);
    localparam int CNT_W = $clog2(RATIO + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RATIO);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [IN_W-1:0]  word_q, word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             out_hs;
    logic             in_hs;

    always_comb begin
        out_valid = stream_enable && (cnt_q != '0);
        out_hs    = out_valid && out_ready;
        // Refill on the same cycle the final slice leaves, so words stream without a bubble.
        in_ready  = enable && ((cnt_q == '0) || ((cnt_q == CNT_ONE) && out_hs));
        in_hs     = in_ready && in_valid;
        out_data  = word_q[IN_W-1 -: OUT_W];
        out_last  = last_q && (cnt_q == CNT_ONE);
        empty     = (cnt_q == '0);

        word_d = word_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        if (flush) begin
            word_d = '0;
            cnt_d  = '0;
            last_d = 1'b0;
        end else if (in_hs) begin
            word_d = in_data;
            cnt_d  = CNT_FULL;
            last_d = in_last;
        end else if (out_hs) begin
            word_d = word_q << OUT_W;
            cnt_d  = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/clb_cfg_sequencer.sv
// Sequences CLB configuration: kicks each CLB in turn, streams its slices, drains padding, then runs.
// Handshakes: a beat transfers on a cycle where both tvalid and tready are high.
module clb_cfg_sequencer
    import fpga_cfg_pkg::*;
#(
    parameter int NUM_CLBS             = 4,
    parameter int IN_DATA_WIDTH        = 8,
    parameter int BITSTREAM_DATA_WIDTH = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [IN_DATA_WIDTH-1:0]        host_bitstream_tdata,
    input  logic                            host_bitstream_tvalid,
    input  logic                            host_bitstream_tlast,
    output logic                            host_bitstream_tready,
    output logic [BITSTREAM_DATA_WIDTH-1:0] cfg_bitstream_tdata,
    output logic                            cfg_bitstream_tvalid,
    output logic                            cfg_bitstream_tlast,
    input  logic [NUM_CLBS-1:0]             cfg_bitstream_tready,
    output logic [NUM_CLBS-1:0]             cfg,
    input  logic [NUM_CLBS-1:0]             cfg_ready,
    output logic                            run,
    output logic                            busy,
    output logic                            error,
    output t_cfg_seq_state                  dbg_state
);

    if (IN_DATA_WIDTH % BITSTREAM_DATA_WIDTH != 0) begin : g_width_check
        $error("BITSTREAM_DATA_WIDTH must divide IN_DATA_WIDTH");
    end
    if (NUM_CLBS < 1) begin : g_clb_check
        $error("NUM_CLBS must be at least 1");
    end

    localparam int IDX_W = (NUM_CLBS > 1) ? $clog2(NUM_CLBS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLBS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    t_cfg_seq_state   state_q, state_d;
    logic [IDX_W-1:0] clb_idx_q, clb_idx_d;
    logic             beats_seen_q, beats_seen_d;
    logic             tlast_seen_q, tlast_seen_d;

    logic sel_tready;
    logic sel_cfg_ready;
    logic is_last_clb;
    logic conv_flush;
    logic conv_enable;
    logic conv_stream;
    logic conv_in_ready;
    logic conv_empty;
    logic host_hs;
    logic out_hs;

    cfg_width_converter #(
        .IN_W  (IN_DATA_WIDTH),
        .OUT_W (BITSTREAM_DATA_WIDTH)
    ) u_conv (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (conv_flush),
        .enable        (conv_enable),
        .stream_enable (conv_stream),
        .in_data       (host_bitstream_tdata),
        .in_valid      (host_bitstream_tvalid),
        .in_last       (host_bitstream_tlast),
        .in_ready      (conv_in_ready),
        .out_data      (cfg_bitstream_tdata),
        .out_valid     (cfg_bitstream_tvalid),
        .out_last      (cfg_bitstream_tlast),
        .out_ready     (sel_tready),
        .empty         (conv_empty)
    );

    // Only the CLB currently being configured is listened to.
    always_comb begin
        sel_tready    = 1'b0;
        sel_cfg_ready = 1'b0;
        cfg           = '0;
        for (int i = 0; i < NUM_CLBS; i++) begin
            if (clb_idx_q == IDX_W'(i)) begin
                sel_tready    = cfg_bitstream_tready[i];
                sel_cfg_ready = cfg_ready[i];
                cfg[i]        = (state_q == KICK);
            end
        end
    end

    always_comb begin
        is_last_clb = (clb_idx_q == LAST_IDX);
        conv_stream = (state_q == STREAM);
        // Nothing past the end of the image is pulled into the shifter.
        conv_enable = ((state_q == KICK) || (state_q == STREAM)) && !tlast_seen_q;
        host_bitstream_tready = (state_q == DRAIN) ? !tlast_seen_q : conv_in_ready;
        host_hs = host_bitstream_tvalid && host_bitstream_tready;
        out_hs  = cfg_bitstream_tvalid && sel_tready;

        run       = (state_q == DONE);
        error     = (state_q == ERROR);
        busy      = (state_q == KICK) || (state_q == STREAM) || (state_q == DRAIN);
        dbg_state = state_q;
    end

    always_comb begin
        state_d      = state_q;
        clb_idx_d    = clb_idx_q;
        beats_seen_d = beats_seen_q;
        tlast_seen_d = tlast_seen_q || (host_hs && host_bitstream_tlast);
        conv_flush   = 1'b0;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d      = KICK;
                    clb_idx_d    = '0;
                    tlast_seen_d = 1'b0;
                    conv_flush   = 1'b1;
                end
            end
            KICK: begin
                state_d      = STREAM;
                beats_seen_d = 1'b0;
            end
            STREAM: begin
                if (out_hs) begin
                    beats_seen_d = 1'b1;
                end
                // A ready left over from an earlier load only counts once this CLB took a beat.
                if (sel_cfg_ready && beats_seen_q) begin
                    if (is_last_clb) begin
                        state_d    = DRAIN;
                        conv_flush = 1'b1;
                    end else begin
                        clb_idx_d = clb_idx_q + IDX_ONE;
                        state_d   = KICK;
                    end
                end else if (tlast_seen_q && conv_empty && !is_last_clb) begin
                    state_d = ERROR;
                end
            end
            DRAIN: begin
                if (tlast_seen_q || (host_hs && host_bitstream_tlast)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clb_idx_q    <= '0;
            beats_seen_q <= 1'b0;
            tlast_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clb_idx_q    <= clb_idx_d;
            beats_seen_q <= beats_seen_d;
            tlast_seen_q <= tlast_seen_d;
        end
    end

endmodule
